// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage sequencer around the external 32-bit ALU
module alu_exec_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_sel,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_overflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            is_branch,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            illegal
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_OR  = 3'b010;
    localparam logic [2:0] SEL_AND = 3'b011;
    localparam logic [2:0] SEL_SLT = 3'b100;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_EXEC   = 2'b01,
        S_BR_TGT = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    state_t r_state;
    state_t w_next;

    // Captured instruction context, consumed during EXEC / BR_TGT
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [2:0]      r_sel;
    logic            r_is_br;
    logic [2:0]      r_br_f3;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;

    // Result registers presented to writeback / PC stage
    logic [XLEN-1:0] r_result;
    logic            r_is_branch;
    logic            r_taken;
    logic [XLEN-1:0] r_target;
    logic            r_illegal;

    // Decode of the incoming instruction
    logic            w_legal;
    logic [2:0]      w_sel;
    logic            w_use_imm;
    logic            w_is_br;
    logic            w_accept;

    // Branch condition from the EXEC-cycle subtraction
    logic            w_eq;
    logic            w_lt;
    logic            w_taken;

    // Decode opcode/funct fields into ALU select, operand B source and legality
    always_comb begin
        w_legal   = 1'b0;
        w_sel     = SEL_ADD;
        w_use_imm = 1'b0;
        w_is_br   = 1'b0;
        case (opcode)
            OP_R: begin
                w_legal = 1'b1;
                case (funct3)
                    3'b000:  w_sel = funct7_5 ? SEL_SUB : SEL_ADD;
                    3'b111:  w_sel = SEL_AND;
                    3'b110:  w_sel = SEL_OR;
                    3'b010:  w_sel = SEL_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_I: begin
                w_legal   = 1'b1;
                w_use_imm = 1'b1;
                // funct7_5 is part of the immediate here, so addi never becomes sub
                case (funct3)
                    3'b000:  w_sel = SEL_ADD;
                    3'b111:  w_sel = SEL_AND;
                    3'b110:  w_sel = SEL_OR;
                    3'b010:  w_sel = SEL_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_BR: begin
                w_sel   = SEL_SUB;
                w_is_br = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE, F3_BLT, F3_BGE: w_legal = 1'b1;
                    default:                        w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && in_valid;

    // Signed less-than from rs1-rs2: sign bit corrected by overflow
    always_comb begin
        w_eq = (alu_out == '0);
        w_lt = alu_out[XLEN-1] ^ alu_overflow;
        case (r_br_f3)
            F3_BEQ:  w_taken = w_eq;
            F3_BNE:  w_taken = ~w_eq;
            F3_BLT:  w_taken = w_lt;
            F3_BGE:  w_taken = ~w_lt;
            default: w_taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and ALU/handshake outputs; ALU ports idle at zero outside EXEC/BR_TGT
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = SEL_ADD;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    w_next = w_legal ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (!rst) begin
                    alu_a   = r_op_a;
                    alu_b   = r_op_b;
                    alu_sel = r_sel;
                end
                w_next = r_is_br ? S_BR_TGT : S_DONE;
            end
            S_BR_TGT: begin
                if (!rst) begin
                    alu_a   = r_pc;
                    alu_b   = r_imm;
                    alu_sel = SEL_ADD;
                end
                w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = ~rst;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture instruction on accept, ALU result in EXEC, branch target in BR_TGT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sel       <= SEL_ADD;
            r_is_br     <= 1'b0;
            r_br_f3     <= 3'b000;
            r_pc        <= '0;
            r_imm       <= '0;
            r_result    <= '0;
            r_is_branch <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a  <= rs1_val;
                        r_op_b  <= w_use_imm ? imm : rs2_val;
                        r_sel   <= w_sel;
                        r_is_br <= w_is_br;
                        r_br_f3 <= funct3;
                        r_pc    <= pc;
                        r_imm   <= imm;
                        if (w_legal) begin
                            r_illegal <= 1'b0;
                        end else begin
                            // Illegal instructions skip the ALU and report straight away
                            r_illegal   <= 1'b1;
                            r_result    <= '0;
                            r_is_branch <= 1'b0;
                            r_taken     <= 1'b0;
                        end
                    end
                end
                S_EXEC: begin
                    r_result    <= alu_out;
                    r_is_branch <= 1'b0;
                    r_taken     <= r_is_br ? w_taken : 1'b0;
                end
                S_BR_TGT: begin
                    r_target    <= alu_out;
                    r_is_branch <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign result        = r_result;
    assign is_branch     = r_is_branch;
    assign branch_taken  = r_taken;
    assign branch_target = r_target;
    assign illegal       = r_illegal;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - self-checking bench for alu_exec_ctrl
module tb_alu_exec_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_out;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        is_branch;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        illegal;

    int checks;
    int failures;

    alu_exec_ctrl #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .imm           (imm),
        .pc            (pc),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_sel       (alu_sel),
        .alu_out       (alu_out),
        .alu_overflow  (alu_overflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .is_branch     (is_branch),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational reference ALU standing in for the real one
    logic [31:0] w_sum;
    logic [31:0] w_dif;
    always_comb begin
        w_sum        = alu_a + alu_b;
        w_dif        = alu_a - alu_b;
        alu_out      = 32'h0;
        alu_overflow = 1'b0;
        case (alu_sel)
            3'b000: begin
                alu_out      = w_sum;
                alu_overflow = (alu_a[31] == alu_b[31]) && (w_sum[31] != alu_a[31]);
            end
            3'b001: begin
                alu_out      = w_dif;
                alu_overflow = (alu_a[31] != alu_b[31]) && (w_dif[31] != alu_a[31]);
            end
            3'b010: alu_out = alu_a | alu_b;
            3'b011: alu_out = alu_a & alu_b;
            3'b100: alu_out = {31'h0, $signed(alu_a) < $signed(alu_b)};
            default: alu_out = 32'h0;
        endcase
    end

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [31:0] p;
        int          lat;
        logic [31:0] res;
        logic        ill;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p);
        @(negedge clk);
        chk("in_ready_before_issue", {31'h0, in_ready}, 32'h1);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        rs1_val  = a;
        rs2_val  = b;
        imm      = im;
        pc       = p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_handshake", {31'h0, out_valid}, 32'h0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_result"}, result, 32'h0);
        chk({tag, "_is_branch"}, {31'h0, is_branch}, 32'h0);
        chk({tag, "_taken"}, {31'h0, branch_taken}, 32'h0);
        chk({tag, "_target"}, branch_target, 32'h0);
        chk({tag, "_illegal"}, {31'h0, illegal}, 32'h0);
        chk({tag, "_alu_a"}, alu_a, 32'h0);
        chk({tag, "_alu_b"}, alu_b, 32'h0);
        chk({tag, "_alu_sel"}, {29'h0, alu_sel}, 32'h0);
    endtask

    initial begin
        int lat;
        logic [31:0] held_result;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 7'h0;
        funct3    = 3'h0;
        funct7_5  = 1'b0;
        rs1_val   = 32'h0;
        rs2_val   = 32'h0;
        imm       = 32'h0;
        pc        = 32'h0;

        //            name        op          f3      f7    rs1           rs2           imm           pc         lat res           ill   br    tk    tgt
        vecs[0]  = '{"add_wrap", 7'b0110011, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,     2, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{"sub",      7'b0110011, 3'b000, 1'b1, 32'h00000003, 32'h00000005, 32'h0,        32'h0,     2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{"slti",     7'b0010011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h0,     2, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{"blt",      7'b1100011, 3'b100, 1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFF0, 32'h100,   3, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 32'h000000F0};
        vecs[4]  = '{"beq",      7'b1100011, 3'b000, 1'b0, 32'h00000009, 32'h00000009, 32'h00000008, 32'h200,   3, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h00000208};
        vecs[5]  = '{"bne",      7'b1100011, 3'b001, 1'b0, 32'h00000009, 32'h00000009, 32'h00000008, 32'h200,   3, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00000208};
        vecs[6]  = '{"load_ill", 7'b0000011, 3'b000, 1'b0, 32'h00000011, 32'h00000022, 32'h00000033, 32'h0,     1, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{"andi",     7'b0010011, 3'b111, 1'b0, 32'h0000F0F0, 32'h12345678, 32'h000000FF, 32'h0,     2, 32'h000000F0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{"or",       7'b0110011, 3'b110, 1'b0, 32'h00000F00, 32'h0000000F, 32'h0,        32'h0,     2, 32'h00000F0F, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{"sll_ill",  7'b0110011, 3'b001, 1'b0, 32'h00000001, 32'h00000001, 32'h0,        32'h0,     1, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{"bge",      7'b1100011, 3'b101, 1'b0, 32'h00000005, 32'hFFFFFFFD, 32'h00000020, 32'h40,    3, 32'h00000008, 1'b0, 1'b1, 1'b1, 32'h00000060};
        vecs[11] = '{"addi_f7",  7'b0010011, 3'b000, 1'b1, 32'h0000000A, 32'h00000003, 32'hFFFFFFFF, 32'h0,     2, 32'h00000009, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{"slt_r",    7'b0110011, 3'b010, 1'b0, 32'h00000005, 32'hFFFFFFFB, 32'h0,        32'h0,     2, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{"br_f3ill", 7'b1100011, 3'b010, 1'b0, 32'h00000001, 32'h00000002, 32'h00000004, 32'h80,    1, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0};

        // Reset: in_ready low while reset is asserted, all outputs zero
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready_during", {31'h0, in_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready_after", {31'h0, in_ready}, 32'h1);
        check_idle_outputs("reset");

        // Add with ALU port check during EXEC
        issue(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
        chk("add_exec_sel", {29'h0, alu_sel}, 32'h0);
        chk("add_exec_a", alu_a, 32'd5);
        chk("add_exec_b", alu_b, 32'd7);
        chk("add_exec_in_ready", {31'h0, in_ready}, 32'h0);
        wait_done(lat);
        chk("add_latency", lat, 32'd2);
        chk("add_result", result, 32'd12);
        chk("add_illegal", {31'h0, illegal}, 32'h0);
        chk("add_is_branch", {31'h0, is_branch}, 32'h0);
        chk("add_done_alu_a", alu_a, 32'h0);
        release_out();

        // Illegal opcode: done one cycle after accept, ALU ports never driven
        issue(7'b0000011, 3'b010, 1'b0, 32'hAAAA5555, 32'h5555AAAA, 32'h1234, 32'h40);
        chk("ill_out_valid", {31'h0, out_valid}, 32'h1);
        chk("ill_flag", {31'h0, illegal}, 32'h1);
        chk("ill_result", result, 32'h0);
        chk("ill_alu_a", alu_a, 32'h0);
        chk("ill_alu_b", alu_b, 32'h0);
        chk("ill_alu_sel", {29'h0, alu_sel}, 32'h0);
        release_out();

        // Back-pressure in DONE with in_valid pulses that must be ignored
        issue(7'b0110011, 3'b000, 1'b0, 32'd20, 32'd22, 32'h0, 32'h0);
        wait_done(lat);
        chk("hold_latency", lat, 32'd2);
        held_result = 32'd42;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0] ? 1'b0 : 1'b1;
            opcode   = 7'b0110011;
            funct3   = 3'b000;
            funct7_5 = 1'b1;
            rs1_val  = 32'd100 + i;
            rs2_val  = 32'd1;
            #1;
            chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk);
            #1;
            chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
            chk("hold_result", result, held_result);
            chk("hold_illegal", {31'h0, illegal}, 32'h0);
            chk("hold_alu_sel", {29'h0, alu_sel}, 32'h0);
        end
        in_valid = 1'b0;
        release_out();
        chk("hold_in_ready_after", {31'h0, in_ready}, 32'h1);

        // Table of single instructions
        for (int v = 0; v < 14; v++) begin
            issue(vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].a, vecs[v].b, vecs[v].im, vecs[v].p);
            wait_done(lat);
            chk({vecs[v].name, "_latency"}, lat, vecs[v].lat);
            chk({vecs[v].name, "_result"}, result, vecs[v].res);
            chk({vecs[v].name, "_illegal"}, {31'h0, illegal}, {31'h0, vecs[v].ill});
            chk({vecs[v].name, "_is_branch"}, {31'h0, is_branch}, {31'h0, vecs[v].br});
            if (vecs[v].br) begin
                chk({vecs[v].name, "_taken"}, {31'h0, branch_taken}, {31'h0, vecs[v].tk});
                chk({vecs[v].name, "_target"}, branch_target, vecs[v].tgt);
            end
            release_out();
        end

        // Reset during EXEC of a branch aborts it
        issue(7'b1100011, 3'b000, 1'b0, 32'd4, 32'd4, 32'h10, 32'h300);
        chk("abort_exec_sel", {29'h0, alu_sel}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready_during", {31'h0, in_ready}, 32'h0);
        chk("abort_out_valid_during", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready_after", {31'h0, in_ready}, 32'h1);
        check_idle_outputs("abort");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_out_valid", {31'h0, out_valid}, 32'h0);
        end
        issue(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0);
        wait_done(lat);
        chk("post_abort_latency", lat, 32'd2);
        chk("post_abort_result", result, 32'd2);
        release_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
